pwr_rail_sequencer: RTL and testbench

//  Ordered power-up/power-down engine for NUM_RAILS board rails, clocked by the 33 kHz sequencing clock.

---
 rtl/pwr_rail_sequencer.sv | 238 +++++++++++++++++++++++
 tb/tb_pwr_rail_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwr_rail_sequencer.sv
// Ordered power-up/power-down engine for NUM_RAILS rails, with PWROK generation and fault latch.
// Optional feature macro: PWRSEQ_AUTO_RETRY_EN (bounded automatic retry out of FAULT).
module pwr_rail_sequencer #(
    parameter int unsigned NUM_RAILS  = 4,
    parameter int unsigned RAIL_DLY   = 60,
    parameter int unsigned PG_TIMEOUT = 334,
    parameter int unsigned PWROK_DLY  = 3334,
    parameter int unsigned OFF_DLY    = 34,
    parameter int unsigned RETRY_DLY  = 6667,
    localparam int unsigned IDX_W     = (NUM_RAILS > 1) ? $clog2(NUM_RAILS) : 1
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iPwrReq,
    input  logic [NUM_RAILS-1:0] iPwrGd,
    output logic [NUM_RAILS-1:0] oRailEn,
    output logic                 oPwrOk,
    output logic                 oFault,
    output logic [IDX_W-1:0]     oFaultRail
);

    localparam int unsigned MAX_A   = (RAIL_DLY > PG_TIMEOUT) ? RAIL_DLY : PG_TIMEOUT;
    localparam int unsigned MAX_B   = (PWROK_DLY > OFF_DLY) ? PWROK_DLY : OFF_DLY;
    localparam int unsigned MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned MAX_DLY = (MAX_C > RETRY_DLY) ? MAX_C : RETRY_DLY;
    localparam int unsigned CNT_W   = $clog2(MAX_DLY + 1);

    localparam logic [CNT_W-1:0] RAIL_LAST  = CNT_W'(RAIL_DLY - 1);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(PG_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] PWROK_LAST = CNT_W'(PWROK_DLY - 1);
    localparam logic [CNT_W-1:0] OFF_LAST   = CNT_W'(OFF_DLY - 1);
`ifdef PWRSEQ_AUTO_RETRY_EN
    localparam logic [CNT_W-1:0] RETRY_LAST = CNT_W'(RETRY_DLY - 1);
`endif
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_RAILS - 1);

    typedef enum logic [2:0] {
        ST_OFF,
        ST_RAIL_ON,
        ST_RAIL_DLY,
        ST_PWROK_WT,
        ST_ON,
        ST_RAIL_OFF,
        ST_FAULT
    } state_t;

    state_t               state_q, state_d;
    logic                 req_s1_q, req_s2_q;
    logic [NUM_RAILS-1:0] pg_s1_q, pg_s2_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [NUM_RAILS-1:0] en_q, en_d;
    logic                 pwrok_q, pwrok_d;
    logic                 fault_q, fault_d;
    logic [IDX_W-1:0]     frail_q, frail_d;
`ifdef PWRSEQ_AUTO_RETRY_EN
    logic [1:0]           retry_q, retry_d;
`endif

    logic                 lost_any;
    logic [IDX_W-1:0]     lost_idx;
    logic                 active;
    logic                 timeout;

    // Rails 0..k enabled, everything above off.
    function automatic logic [NUM_RAILS-1:0] en_mask(input logic [IDX_W-1:0] k);
        logic [NUM_RAILS-1:0] m;
        for (int unsigned i = 0; i < NUM_RAILS; i++) begin
            m[i] = (i <= 32'(k));
        end
        return m;
    endfunction

    always_ff @(posedge iClk) begin
        if (iRst) begin
            req_s1_q <= 1'b0;
            req_s2_q <= 1'b0;
            pg_s1_q  <= '0;
            pg_s2_q  <= '0;
        end else begin
            req_s1_q <= iPwrReq;
            req_s2_q <= req_s1_q;
            pg_s1_q  <= iPwrGd;
            pg_s2_q  <= pg_s1_q;
        end
    end

    // Confirmed rails: below idx while waiting for PG[idx], up to and including idx afterwards.
    always_comb begin
        lost_any = 1'b0;
        lost_idx = '0;
        for (int unsigned i = 0; i < NUM_RAILS; i++) begin
            if (!lost_any && !pg_s2_q[i] &&
                ((i < 32'(idx_q)) || ((state_q != ST_RAIL_ON) && (i == 32'(idx_q))))) begin
                lost_any = 1'b1;
                lost_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        en_d    = en_q;
        pwrok_d = pwrok_q;
        fault_d = fault_q;
        frail_d = frail_q;
`ifdef PWRSEQ_AUTO_RETRY_EN
        retry_d = retry_q;
`endif
        active  = state_q inside {ST_RAIL_ON, ST_RAIL_DLY, ST_PWROK_WT, ST_ON};
        timeout = (state_q == ST_RAIL_ON) && !pg_s2_q[idx_q] && (cnt_q == TO_LAST);

        if (active && (lost_any || timeout)) begin
            state_d = ST_FAULT;
            cnt_d   = '0;
            en_d    = '0;
            pwrok_d = 1'b0;
            fault_d = 1'b1;
            frail_d = lost_any ? lost_idx : idx_q;
        end else if (active && !req_s2_q) begin
            // idx always names the highest enabled rail, so it is dropped on this edge.
            cnt_d   = '0;
            pwrok_d = 1'b0;
            if (idx_q == '0) begin
                state_d = ST_OFF;
                en_d    = '0;
            end else begin
                state_d = ST_RAIL_OFF;
                idx_d   = idx_q - 1'b1;
                en_d    = en_mask(idx_q - 1'b1);
            end
        end else begin
            case (state_q)
                ST_OFF: begin
                    if (req_s2_q) begin
                        state_d = ST_RAIL_ON;
                        cnt_d   = '0;
                        idx_d   = '0;
                        en_d    = en_mask('0);
                    end
                end
                ST_RAIL_ON: begin
                    if (pg_s2_q[idx_q]) begin
                        state_d = (idx_q == LAST_IDX) ? ST_PWROK_WT : ST_RAIL_DLY;
                        cnt_d   = '0;
                    end
                end
                ST_RAIL_DLY: begin
                    if (cnt_q == RAIL_LAST) begin
                        state_d = ST_RAIL_ON;
                        cnt_d   = '0;
                        idx_d   = idx_q + 1'b1;
                        en_d    = en_mask(idx_q + 1'b1);
                    end
                end
                ST_PWROK_WT: begin
                    if (cnt_q == PWROK_LAST) begin
                        state_d = ST_ON;
                        cnt_d   = '0;
                        pwrok_d = 1'b1;
                    end
                end
                ST_RAIL_OFF: begin
                    if (cnt_q == OFF_LAST) begin
                        cnt_d = '0;
                        if (idx_q == '0) begin
                            state_d = ST_OFF;
                            en_d    = '0;
                        end else begin
                            idx_d = idx_q - 1'b1;
                            en_d  = en_mask(idx_q - 1'b1);
                        end
                    end
                end
                ST_FAULT: begin
                    if (!req_s2_q) begin
                        state_d = ST_OFF;
                        cnt_d   = '0;
                        idx_d   = '0;
                        fault_d = 1'b0;
                        frail_d = '0;
`ifdef PWRSEQ_AUTO_RETRY_EN
                    end else if ((retry_q != 2'd3) && (cnt_q == RETRY_LAST)) begin
                        state_d = ST_RAIL_ON;
                        cnt_d   = '0;
                        idx_d   = '0;
                        en_d    = en_mask('0);
                        fault_d = 1'b0;
                        frail_d = '0;
                        retry_d = retry_q + 1'b1;
`endif
                    end
                end
                default: ;
            endcase
        end

`ifdef PWRSEQ_AUTO_RETRY_EN
        if ((state_d == ST_OFF) || (state_d == ST_ON)) begin
            retry_d = '0;
        end
`endif
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            idx_q   <= '0;
            en_q    <= '0;
            pwrok_q <= 1'b0;
            fault_q <= 1'b0;
            frail_q <= '0;
`ifdef PWRSEQ_AUTO_RETRY_EN
            retry_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            en_q    <= en_d;
            pwrok_q <= pwrok_d;
            fault_q <= fault_d;
            frail_q <= frail_d;
`ifdef PWRSEQ_AUTO_RETRY_EN
            retry_q <= retry_d;
`endif
        end
    end

    assign oRailEn    = en_q;
    assign oPwrOk     = pwrok_q;
    assign oFault     = fault_q;
    assign oFaultRail = frail_q;

endmodule

// File: tb/tb_pwr_rail_sequencer.sv
// Directed bench for pwr_rail_sequencer: latencies, power-down order, faults, reset, retry behaviour.
module tb_pwr_rail_sequencer;

    localparam int NR        = 4;
    localparam int SEL_PWROK = 4;
    localparam int SEL_FAULT = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic [NR-1:0] pg;
    logic [NR-1:0] rail_en;
    logic          pwr_ok;
    logic          fault;
    logic [1:0]    fault_rail;

    int n_checks = 0;
    int n_errors = 0;
    int fault_seen = 0;
    bit watch_fault = 1'b0;

    pwr_rail_sequencer dut (
        .iClk       (clk),
        .iRst       (rst),
        .iPwrReq    (req),
        .iPwrGd     (pg),
        .oRailEn    (rail_en),
        .oPwrOk     (pwr_ok),
        .oFault     (fault),
        .oFaultRail (fault_rail)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (watch_fault && fault) fault_seen++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic sig_sel(input int sel);
        if (sel < NR) return rail_en[sel];
        else if (sel == SEL_PWROK) return pwr_ok;
        else return fault;
    endfunction

    // Number of clock edges until the selected output equals val; -1 if the bound expires.
    task automatic wait_sig(input int sel, input logic val, input int limit, output int n);
        bit done;
        n = -1;
        done = 1'b0;
        for (int k = 1; k <= limit && !done; k++) begin
            @(posedge clk);
            #1;
            if (sig_sel(sel) === val) begin
                n = k;
                done = 1'b1;
            end
        end
    endtask

    task automatic power_up();
        int n;
        req = 1'b1;
        wait_sig(0, 1'b1, 10, n);
        check_eq("pu_en0_lat", n, 3);
        for (int i = 0; i < NR; i++) begin
            tick(5);
            pg[i] = 1'b1;
            if (i < NR - 1) begin
                wait_sig(i + 1, 1'b1, 200, n);
                check_eq("pu_en_next_lat", n, 63);
            end else begin
                wait_sig(SEL_PWROK, 1'b1, 4000, n);
                check_eq("pu_pwrok_lat", n, 3337);
            end
        end
        check_eq("pu_en_all", rail_en, 4'hF);
        check_eq("pu_fault_clear", fault, 0);
    endtask

    task automatic clear_fault();
        int n;
        req = 1'b0;
        wait_sig(SEL_FAULT, 1'b0, 10, n);
        check_eq("fault_clear_lat", n, 3);
        check_eq("fault_rail_clear", fault_rail, 0);
        pg = '0;
        tick(5);
    endtask

    initial begin
        int n;
        int bad;
        rst = 1'b1;
        req = 1'b0;
        pg  = '0;
        tick(3);
        check_eq("rst_en", rail_en, 0);
        check_eq("rst_pwrok", pwr_ok, 0);
        check_eq("rst_fault", fault, 0);
        check_eq("rst_frail", fault_rail, 0);
        rst = 1'b0;
        tick(5);

        // Full power-up with PG echoed 5 cycles after each enable
        watch_fault = 1'b1;
        power_up();
        watch_fault = 1'b0;
        check_eq("pu_no_fault_seen", fault_seen, 0);

        // Ordered power-down from ON
        req = 1'b0;
        wait_sig(SEL_PWROK, 1'b0, 10, n);
        check_eq("pd_pwrok_lat", n, 3);
        check_eq("pd_en_first", rail_en, 4'b0111);
        wait_sig(2, 1'b0, 60, n);
        check_eq("pd_en2_gap", n, 34);
        check_eq("pd_en_2", rail_en, 4'b0011);
        wait_sig(1, 1'b0, 60, n);
        check_eq("pd_en1_gap", n, 34);
        check_eq("pd_en_1", rail_en, 4'b0001);
        wait_sig(0, 1'b0, 60, n);
        check_eq("pd_en0_gap", n, 34);
        tick(50);
        check_eq("pd_off_hold", rail_en, 0);
        pg = '0;
        tick(5);

        // PG[2] never rises: timeout fault on rail 2
        req = 1'b1;
        wait_sig(0, 1'b1, 10, n);
        check_eq("to_en0_lat", n, 3);
        tick(5);
        pg[0] = 1'b1;
        wait_sig(1, 1'b1, 200, n);
        check_eq("to_en1_lat", n, 63);
        tick(5);
        pg[1] = 1'b1;
        wait_sig(2, 1'b1, 200, n);
        check_eq("to_en2_lat", n, 63);
        wait_sig(SEL_FAULT, 1'b1, 400, n);
        check_eq("to_fault_lat", n, 334);
        check_eq("to_en_off", rail_en, 0);
        check_eq("to_frail", fault_rail, 2);
        check_eq("to_pwrok", pwr_ok, 0);
        clear_fault();

        // Rail loss in ON: PG[1] low for 3 cycles
        power_up();
        pg[1] = 1'b0;
        wait_sig(SEL_FAULT, 1'b1, 10, n);
        pg[1] = 1'b1;
        check_eq("loss1_lat", n, 3);
        check_eq("loss1_frail", fault_rail, 1);
        check_eq("loss1_en", rail_en, 0);
        check_eq("loss1_pwrok", pwr_ok, 0);
        clear_fault();

        // Rail loss on PG[1] and PG[3] together reports the lower index
        power_up();
        pg[1] = 1'b0;
        pg[3] = 1'b0;
        wait_sig(SEL_FAULT, 1'b1, 10, n);
        check_eq("loss13_lat", n, 3);
        check_eq("loss13_frail", fault_rail, 1);
        clear_fault();

        // Reset during RAIL_DLY of rail 1, then restart from rail 0
        req = 1'b1;
        wait_sig(0, 1'b1, 10, n);
        tick(5);
        pg[0] = 1'b1;
        wait_sig(1, 1'b1, 200, n);
        tick(5);
        pg[1] = 1'b1;
        tick(10);
        check_eq("rd_en_pre", rail_en, 4'b0011);
        rst = 1'b1;
        tick(1);
        check_eq("rd_rst_en", rail_en, 0);
        check_eq("rd_rst_pwrok", pwr_ok, 0);
        check_eq("rd_rst_fault", fault, 0);
        tick(2);
        rst = 1'b0;
        wait_sig(0, 1'b1, 10, n);
        check_eq("rd_restart_en0", n, 3);
        check_eq("rd_restart_mask", rail_en, 4'b0001);
        wait_sig(1, 1'b1, 200, n);
        check_eq("rd_restart_en1", n, 61);
        rst = 1'b1;
        req = 1'b0;
        pg  = '0;
        tick(3);
        rst = 1'b0;
        tick(5);

        // PG[0] stuck low with request held
        req = 1'b1;
        wait_sig(0, 1'b1, 10, n);
        check_eq("stk_en0_lat", n, 3);
        wait_sig(SEL_FAULT, 1'b1, 400, n);
        check_eq("stk_fault_lat", n, 334);
        check_eq("stk_frail", fault_rail, 0);
`ifdef PWRSEQ_AUTO_RETRY_EN
        for (int r = 0; r < 3; r++) begin
            wait_sig(SEL_FAULT, 1'b0, 7000, n);
            check_eq("retry_gap", n, 6667);
            check_eq("retry_en", rail_en, 4'b0001);
            wait_sig(SEL_FAULT, 1'b1, 400, n);
            check_eq("retry_to", n, 334);
        end
`endif
        bad = 0;
        for (int k = 0; k < 7200; k++) begin
            tick(1);
            if (!fault || (rail_en != 0)) bad++;
        end
        check_eq("stk_fault_hold", bad, 0);
        clear_fault();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
